// File: rtl/axon_scanner_pkg.sv
// Shared definitions for the axon scanner: scan FSM state encoding.
package axon_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit of vec.
module lowest_set_bit #(
    parameter int IDX_W = 3
) (
    input  logic [(1<<IDX_W)-1:0] vec,
    output logic [IDX_W-1:0]      idx,
    output logic                  any_set
);

    localparam int N = 1 << IDX_W;

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        any_set = |vec;
    end

endmodule

// File: rtl/axon_scanner.sv
// Serialises a per-step axon spike vector into a valid/ready stream of
// axon indices, lowest index first, with spike count and done pulse.
module axon_scanner
    import axon_scanner_pkg::*;
#(
    parameter int AXON_CNT_BIT_WIDTH = 3,
    parameter     X_ID               = "1",
    parameter     Y_ID               = "1"
) (
    input  logic                                neuron_clk,
    input  logic                                neuron_reset,
    input  logic                                start,
    input  logic [(1<<AXON_CNT_BIT_WIDTH)-1:0]  spike,
    output logic                                axon_valid,
    output logic [AXON_CNT_BIT_WIDTH-1:0]       axon_id,
    input  logic                                axon_ready,
    output logic                                busy,
    output logic                                scan_done,
    output logic [AXON_CNT_BIT_WIDTH:0]         spike_count,
    output logic                                overrun
);

    localparam int NUM_VEC = 1 << AXON_CNT_BIT_WIDTH;

    // Tile ids only name simulation dumps; reject empty ids at elaboration.
    if (X_ID == "" || Y_ID == "") begin : g_bad_tile_id
        $error("axon_scanner: X_ID/Y_ID must not be empty");
    end

    scan_state_t          state, state_nxt;
    logic [NUM_VEC-1:0]   pending;
    logic [NUM_VEC-1:0]   pending_clr;
    logic                 any_set;
    logic                 handshake;

    lowest_set_bit #(.IDX_W(AXON_CNT_BIT_WIDTH)) u_lsb (
        .vec     (pending),
        .idx     (axon_id),
        .any_set (any_set)
    );

    // x & (x-1) drops exactly the lowest set bit, i.e. the axon on offer.
    assign pending_clr = pending & (pending - 1'b1);
    assign axon_valid  = (state == ST_SCAN) && any_set;
    assign busy        = (state != ST_IDLE);
    assign scan_done   = (state == ST_DONE);
    assign handshake   = axon_valid && axon_ready;

    // State register.
    always_ff @(posedge neuron_clk) begin
        if (neuron_reset) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (spike != '0) ? ST_SCAN : ST_DONE;
            ST_SCAN: if (handshake && pending_clr == '0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pending vector, spike count and sticky overrun flag.
    always_ff @(posedge neuron_clk) begin
        if (neuron_reset) begin
            pending     <= '0;
            spike_count <= '0;
            overrun     <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                pending     <= spike;
                spike_count <= '0;
            end else if (handshake) begin
                pending     <= pending_clr;
                spike_count <= spike_count + 1'b1;
            end
            if (start && state != ST_IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axon_scanner.sv
// Randomised self-checking bench for axon_scanner against a queue model.
module tb_axon_scanner;

    localparam int W = 3;
    localparam int N = 1 << W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  spike = '0;
    logic          axon_ready = 1'b0;
    logic          axon_valid;
    logic [W-1:0]  axon_id;
    logic          busy;
    logic          scan_done;
    logic [W:0]    spike_count;
    logic          overrun;

    int checks = 0;
    int failures = 0;
    bit ovr_exp = 1'b0;

    axon_scanner #(.AXON_CNT_BIT_WIDTH(W), .X_ID("1"), .Y_ID("1")) dut (
        .neuron_clk   (clk),
        .neuron_reset (rst),
        .start        (start),
        .spike        (spike),
        .axon_valid   (axon_valid),
        .axon_id      (axon_id),
        .axon_ready   (axon_ready),
        .busy         (busy),
        .scan_done    (scan_done),
        .spike_count  (spike_count),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One time step. mode: 0 ready always high, 1 random ready, 2 stall 3 cycles.
    // poke: pulse start mid-scan; rst_mid: reset right after the first handshake.
    // Called and returns at a negedge.
    task automatic run_step(input logic [N-1:0] vec, input int mode,
                            input bit poke, input bit rst_mid);
        int  q[$];
        int  n;
        int  k;
        bit  fin;
        bit  r;
        for (int i = 0; i < N; i++) if (vec[i]) q.push_back(i);
        n = 0;
        spike = vec;
        start = 1'b1;
        axon_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        spike = '0;
        k = 0;
        fin = 1'b0;
        while (!fin && k < 200) begin
            if (q.size() != 0) begin
                chk("valid", axon_valid, 1);
                chk("id", axon_id, q[0]);
                chk("busy", busy, 1);
                chk("done_low", scan_done, 0);
                chk("count_run", spike_count, n);
                if (rst_mid && n == 1) begin
                    rst = 1'b1;
                    axon_ready = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    ovr_exp = 1'b0;
                    chk("rst_valid", axon_valid, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_count", spike_count, 0);
                    chk("rst_done", scan_done, 0);
                    chk("rst_overrun", overrun, 0);
                    @(negedge clk);
                    chk("rst_no_done", scan_done, 0);
                    return;
                end
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (k >= 3);
                endcase
                axon_ready = r;
                if (poke && k == 1) begin
                    start = 1'b1;
                    spike = N'($urandom);
                    ovr_exp = 1'b1;
                end
                if (r) begin
                    void'(q.pop_front());
                    n++;
                end
            end else begin
                chk("done_pulse", scan_done, 1);
                chk("done_valid", axon_valid, 0);
                chk("done_count", spike_count, n);
                chk("overrun", overrun, ovr_exp);
                axon_ready = 1'b0;
                fin = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            spike = '0;
            k++;
        end
        if (!fin) chk("timeout", 0, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", scan_done, 0);
        chk("idle_count_hold", spike_count, n);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_valid", axon_valid, 0);
        chk("reset_id", axon_id, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", scan_done, 0);
        chk("reset_count", spike_count, 0);
        chk("reset_overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        run_step(8'b1010_0100, 0, 1'b0, 1'b0);
        run_step(8'h00,        0, 1'b0, 1'b0);
        run_step(8'hFF,        0, 1'b0, 1'b0);
        run_step(8'b0001_0100, 2, 1'b0, 1'b0);
        run_step(8'b1010_0100, 0, 1'b1, 1'b0);
        run_step(8'b0110_0001, 1, 1'b0, 1'b0);
        run_step(8'b1010_0100, 0, 1'b0, 1'b1);
        run_step(8'b0000_0010, 0, 1'b0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            if ($urandom_range(0, 7) == 0) v = '0;
            run_step(v, 1, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
